alarm_timekeeper: RTL
=====================

ALARM_TIMEKEEPER -- requirements
Module: alarm_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, mclk cycles per one-second tick.
REQ-002 SHALL have parameter SNOOZE_MIN, default 9, snooze length in minutes (1..15).
REQ-003 SHALL have parameter RING_MAX_MIN, default 10, minutes of ringing before auto-stop (1..15).
REQ-004 SHALL have parameter MODE_24H, default 1; 0 selects 12-hour display format.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with ports: mclk in 1 (system clock), rst_n in 1 (sync active-low reset).
REQ-006 SHALL have ports: fast_mode in 1 (each tick advances one minute); load_time in 1 (pulse, load time); load_alarm in 1 (pulse, load alarm); set_value in 16 (BCD HHMM).
REQ-007 SHALL have ports: alarm_en in 1; snooze in 1 (pulse); alarm_off in 1 (pulse).
REQ-008 SHALL have outputs: time_hhmm out 16 (BCD display time); time_ss out 8 (BCD seconds); alarm_hhmm out 16 (BCD, always 24h); pm out 1; sec_pulse out 1; min_pulse out 1; ringing out 1; alarm_state out 2.

Function
REQ-009 Prescaler SHALL count 0..TICK_DIV-1; sec_pulse high exactly one cycle on wrap; first pulse TICK_DIV cycles after reset release.
REQ-010 Normal mode: sec_pulse SHALL advance ss; ss 59->00 SHALL advance minute, with min_pulse high in that same cycle.
REQ-011 Fast mode: each sec_pulse SHALL advance minute and assert min_pulse; ss SHALL be forced to 00.
REQ-012 Counting SHALL be pure BCD: digit 9->0 with carry; MM 59->00 carries to hour; HH 23->00; no binary intermediates visible.
REQ-013 load_time with valid set_value SHALL set HH:MM, ss=00, prescaler=0 on next edge; load wins over same-cycle tick; no min_pulse generated.
REQ-014 load_alarm with valid set_value SHALL set alarm_hhmm on next edge.
REQ-015 Invalid set_value (any digit >9, MM>59, HH>23) SHALL be ignored; registers unchanged.
REQ-016 alarm_state encoding SHALL be IDLE=00, RINGING=01, SNOOZE=10; ringing = (state==RINGING).
REQ-017 IDLE->RINGING SHALL occur at the edge where a counted minute advance makes HH:MM equal alarm_hhmm and alarm_en=1; a load_time landing on the alarm time SHALL NOT trigger.
REQ-018 RINGING: alarm_off or alarm_en=0 -> IDLE; snooze -> SNOOZE with snooze counter=SNOOZE_MIN; RING_MAX_MIN min_pulses while ringing -> IDLE.
REQ-019 SNOOZE: each min_pulse decrements counter; min_pulse with counter==1 -> RINGING (ring counter reset); alarm_off or alarm_en=0 -> IDLE.
REQ-020 Simultaneous alarm_off and snooze SHALL resolve to IDLE; snooze in IDLE or SNOOZE SHALL be ignored.
REQ-021 MODE_24H=0: displayed hour 00->12 pm=0; 01..11 unchanged pm=0; 12->12 pm=1; 13..23->01..11 pm=1. MODE_24H=1: pm SHALL be HH>=12.
REQ-022 All outputs SHALL be registered or decoded from registers only; no input-to-output combinational path.

Reset
REQ-023 rst_n=0 at an mclk edge SHALL set time 00:00:00, alarm 00:00, prescaler 0, state IDLE, snooze/ring counters 0, sec_pulse=min_pulse=0.
REQ-024 During/after reset, time_hhmm SHALL read 0000 (MODE_24H=1) or 1200 with pm=0 (MODE_24H=0).
REQ-025 Reset mid-ringing or mid-snooze SHALL return to IDLE with no residual pulse.

Structure
REQ-026 Shared package al_pkg SHALL hold the alarm-state enum, BCD HHMM typedef and BCD validity function.
REQ-027 BCD HH:MM:SS counter SHALL be sub-module bcd_time_counter; prescaler, alarm FSM and 12h mapping stay in alarm_timekeeper.

Verification (TICK_DIV=4, SNOOZE_MIN=2, RING_MAX_MIN=3)
REQ-028 Load 2359, run 60 ticks -> time 0000, ss 00, single min_pulse at rollover.
REQ-029 Load alarm 0701, time 0700, alarm_en=1, fast_mode=1 -> ringing at edge time becomes 0701; alarm_state=01.
REQ-030 Ringing, pulse snooze -> state 10; after 2 min_pulses -> state 01; 3 further min_pulses -> state 00.
REQ-031 set_value 2460 or 1A00 with load_time -> time unchanged; load_alarm 1260 -> alarm unchanged.
REQ-032 MODE_24H=0, load 0000/1200/1300 -> time_hhmm 1200 pm0 / 1200 pm1 / 0100 pm1.
REQ-033 Ringing with snooze and alarm_off same cycle -> IDLE; rst_n low during SNOOZE -> IDLE, time 00:00:00.

Source files
------------

// File: rtl/al_pkg.sv
// Shared types for the alarm timekeeper.
//   alarm_state_t  : alarm FSM state (IDLE=00, RINGING=01, SNOOZE=10)
//   bcd_hhmm_t     : packed BCD HHMM {h1,h0,m1,m0}
//   bcd_hhmm_valid : true when every digit is 0..9, MM <= 59 and HH <= 23
package al_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RINGING = 2'b01,
      ST_SNOOZE  = 2'b10
   } alarm_state_t;

   typedef logic [15:0] bcd_hhmm_t;

   function automatic logic bcd_hhmm_valid(input bcd_hhmm_t v);
      logic [3:0] h1;
      logic [3:0] h0;
      logic [3:0] m1;
      logic [3:0] m0;
      h1 = v[15:12];
      h0 = v[11:8];
      m1 = v[7:4];
      m0 = v[3:0];
      return (h0 <= 4'd9) && (m0 <= 4'd9) && (m1 <= 4'd5) &&
             ((h1 <= 4'd1) || ((h1 == 4'd2) && (h0 <= 4'd3)));
   endfunction

endpackage

// File: rtl/alarm_timekeeper_if.sv
// Control/status bundle of the alarm timekeeper.
//   master : drives controls (fast_mode, load_time, load_alarm, set_value,
//            alarm_en, snooze, alarm_off), observes status
//   slave  : the timekeeper; drives time_hhmm, time_ss, alarm_hhmm, pm,
//            sec_pulse, min_pulse, ringing, alarm_state
interface alarm_timekeeper_if;
   import al_pkg::*;

   logic        fast_mode;
   logic        load_time;
   logic        load_alarm;
   bcd_hhmm_t   set_value;
   logic        alarm_en;
   logic        snooze;
   logic        alarm_off;

   bcd_hhmm_t   time_hhmm;
   logic [7:0]  time_ss;
   bcd_hhmm_t   alarm_hhmm;
   logic        pm;
   logic        sec_pulse;
   logic        min_pulse;
   logic        ringing;
   logic [1:0]  alarm_state;

   modport master (
      output fast_mode, load_time, load_alarm, set_value, alarm_en, snooze, alarm_off,
      input  time_hhmm, time_ss, alarm_hhmm, pm, sec_pulse, min_pulse, ringing, alarm_state
   );

   modport slave (
      input  fast_mode, load_time, load_alarm, set_value, alarm_en, snooze, alarm_off,
      output time_hhmm, time_ss, alarm_hhmm, pm, sec_pulse, min_pulse, ringing, alarm_state
   );

endinterface

// File: rtl/bcd_time_counter.sv
// BCD HH:MM:SS time-of-day counter (24h internal format).
//   clk, rst_n  : clock, synchronous active-low reset
//   tick        : one-second tick (already suppressed by the caller on load)
//   fast_mode   : each tick advances one minute, seconds held at 00
//   load        : load HH:MM from load_val, seconds cleared
//   hhmm, ss    : current BCD time
//   min_pulse   : registered, high in the cycle the new minute is visible
//   min_adv     : combinational, a counted minute advance happens this edge
//   adv_hhmm    : combinational, HH:MM after this edge's counted advance
module bcd_time_counter
   import al_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       fast_mode,
   input  logic       load,
   input  bcd_hhmm_t  load_val,
   output bcd_hhmm_t  hhmm,
   output logic [7:0] ss,
   output logic       min_pulse,
   output logic       min_adv,
   output bcd_hhmm_t  adv_hhmm
);

   logic [7:0] ss_nxt;

   function automatic bcd_hhmm_t inc_minute(input bcd_hhmm_t t);
      bcd_hhmm_t r;
      r = t;
      if (t[3:0] != 4'd9) begin
         r[3:0] = t[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (t[7:4] != 4'd5) begin
            r[7:4] = t[7:4] + 4'd1;
         end else begin
            r[7:4] = 4'd0;
            if (t[15:8] == 8'h23) begin
               r[15:8] = 8'h00;
            end else if (t[11:8] == 4'd9) begin
               r[11:8]  = 4'd0;
               r[15:12] = t[15:12] + 4'd1;
            end else begin
               r[11:8] = t[11:8] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      min_adv  = tick && !load && (fast_mode || (ss == 8'h59));
      adv_hhmm = min_adv ? inc_minute(hhmm) : hhmm;
      ss_nxt   = ss;
      if (tick) begin
         if (fast_mode || (ss == 8'h59)) ss_nxt = 8'h00;
         else if (ss[3:0] == 4'd9)       ss_nxt = {ss[7:4] + 4'd1, 4'd0};
         else                            ss_nxt = {ss[7:4], ss[3:0] + 4'd1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hhmm      <= 16'h0000;
         ss        <= 8'h00;
         min_pulse <= 1'b0;
      end else if (load) begin
         hhmm      <= load_val;
         ss        <= 8'h00;
         min_pulse <= 1'b0;
      end else begin
         hhmm      <= adv_hhmm;
         ss        <= ss_nxt;
         min_pulse <= min_adv;
      end
   end

endmodule

// File: rtl/alarm_timekeeper.sv
// Alarm clock: seconds prescaler, BCD time counter, alarm register,
// ring/snooze FSM and 12/24-hour display mapping.
//   mclk, rst_n : clock, synchronous active-low reset
//   io          : alarm_timekeeper_if.slave (controls in, status out)
// Parameters: TICK_DIV (mclk cycles per second), SNOOZE_MIN, RING_MAX_MIN,
// MODE_24H (0 = 12-hour display with pm flag).
module alarm_timekeeper
   import al_pkg::*;
#(
   parameter int TICK_DIV     = 25000000,
   parameter int SNOOZE_MIN   = 9,
   parameter int RING_MAX_MIN = 10,
   parameter int MODE_24H     = 1
) (
   input logic               mclk,
   input logic               rst_n,
   alarm_timekeeper_if.slave io
);

   localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [3:0] SNZ_INIT  = 4'(SNOOZE_MIN);
   localparam logic [3:0] RING_LAST = 4'(RING_MAX_MIN - 1);

   logic [PW-1:0] presc;
   logic          sec_q;
   logic          wrap;
   logic          tick;
   logic          load_ok;
   logic          alarm_ok;

   bcd_hhmm_t     hhmm;
   bcd_hhmm_t     adv_hhmm;
   bcd_hhmm_t     alarm_q;
   logic [7:0]    ss;
   logic          min_pulse;
   logic          min_adv;

   alarm_state_t  state, state_n;
   logic [3:0]    ring_cnt, ring_n;
   logic [3:0]    snz_cnt, snz_n;

   logic [4:0]    hb;
   logic [4:0]    db;
   logic [7:0]    disp_hh;
   logic          pm_d;

   assign load_ok  = io.load_time  && bcd_hhmm_valid(io.set_value);
   assign alarm_ok = io.load_alarm && bcd_hhmm_valid(io.set_value);
   assign wrap     = (presc == PW'(TICK_DIV - 1));
   // A valid time load restarts the second, so it swallows a coincident tick.
   assign tick     = wrap && !load_ok;

   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         presc <= '0;
         sec_q <= 1'b0;
      end else if (load_ok) begin
         presc <= '0;
         sec_q <= 1'b0;
      end else if (wrap) begin
         presc <= '0;
         sec_q <= 1'b1;
      end else begin
         presc <= presc + 1'b1;
         sec_q <= 1'b0;
      end
   end

   always_ff @(posedge mclk) begin
      if (!rst_n)        alarm_q <= 16'h0000;
      else if (alarm_ok) alarm_q <= io.set_value;
   end

   bcd_time_counter u_cnt (
      .clk       (mclk),
      .rst_n     (rst_n),
      .tick      (tick),
      .fast_mode (io.fast_mode),
      .load      (load_ok),
      .load_val  (io.set_value),
      .hhmm      (hhmm),
      .ss        (ss),
      .min_pulse (min_pulse),
      .min_adv   (min_adv),
      .adv_hhmm  (adv_hhmm)
   );

   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ring_cnt <= 4'd0;
         snz_cnt  <= 4'd0;
      end else begin
         state    <= state_n;
         ring_cnt <= ring_n;
         snz_cnt  <= snz_n;
      end
   end

   // Trigger compares the post-advance time, so only a counted minute
   // (never a load) can land on the alarm. Off/disable outrank snooze.
   always_comb begin
      state_n = state;
      ring_n  = ring_cnt;
      snz_n   = snz_cnt;
      case (state)
         ST_IDLE: begin
            if (min_adv && io.alarm_en && (adv_hhmm == alarm_q)) begin
               state_n = ST_RINGING;
               ring_n  = 4'd0;
            end
         end
         ST_RINGING: begin
            if (io.alarm_off || !io.alarm_en) begin
               state_n = ST_IDLE;
               ring_n  = 4'd0;
            end else if (io.snooze) begin
               state_n = ST_SNOOZE;
               snz_n   = SNZ_INIT;
               ring_n  = 4'd0;
            end else if (min_adv) begin
               if (ring_cnt >= RING_LAST) begin
                  state_n = ST_IDLE;
                  ring_n  = 4'd0;
               end else begin
                  ring_n = ring_cnt + 4'd1;
               end
            end
         end
         ST_SNOOZE: begin
            if (io.alarm_off || !io.alarm_en) begin
               state_n = ST_IDLE;
               snz_n   = 4'd0;
            end else if (min_adv) begin
               if (snz_cnt <= 4'd1) begin
                  state_n = ST_RINGING;
                  ring_n  = 4'd0;
                  snz_n   = 4'd0;
               end else begin
                  snz_n = snz_cnt - 4'd1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Hour display mapping; binary only inside this decode.
   always_comb begin
      hb   = 5'(hhmm[15:12]) * 5'd10 + 5'(hhmm[11:8]);
      pm_d = (hb >= 5'd12);
      db   = hb;
      if (hb == 5'd0)       db = 5'd12;
      else if (hb > 5'd12)  db = hb - 5'd12;
      if (MODE_24H != 0)    disp_hh = hhmm[15:8];
      else if (db >= 5'd10) disp_hh = {4'd1, 4'(db - 5'd10)};
      else                  disp_hh = {4'd0, db[3:0]};
   end

   assign io.time_hhmm   = {disp_hh, hhmm[7:0]};
   assign io.time_ss     = ss;
   assign io.alarm_hhmm  = alarm_q;
   assign io.pm          = pm_d;
   assign io.sec_pulse   = sec_q;
   assign io.min_pulse   = min_pulse;
   assign io.ringing     = (state == ST_RINGING);
   assign io.alarm_state = state;

endmodule
